// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit with an internal program memory.
// A program is written into memory while IDLE; start launches sequential
// fetching that presents one word per cycle over a valid/ready output,
// honouring consumer back-pressure, branch redirects, stop and a HALT encoding.
module instr_fetch_unit #(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           ADDR_W    = 8,
  parameter logic [DATA_W-1:0]     HALT_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              busy,
  output logic              load_err,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Program storage: deliberately outside the reset domain so a reset or stop
  // never disturbs a loaded program.
  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              load_err_q, load_err_d;
  logic [15:0]       count_q, count_d;

  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rd_s;
  logic              handshake_s;
  logic [15:0]       count_inc_s;

  assign mem_rd_s    = mem_q[pc_q];
  assign handshake_s = out_valid_q & out_ready;
  // Saturate rather than wrap so a long run never reports a small count.
  assign count_inc_s = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);

  // Program-load write port, only enabled from IDLE.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Next-state logic: stop beats redirect beats normal fetch/accept.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    count_d     = count_q;
    load_err_d  = 1'b0;
    mem_we_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        mem_we_s    = load_en;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          // Fetch begins next cycle, so nothing is presented on this one.
          state_d = ST_FETCH;
          pc_d    = start_addr;
          count_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        load_err_d = load_en;
        if (stop) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else if (redirect_valid) begin
          // Pending word is squashed and not counted, even if accepted now.
          state_d     = ST_FETCH;
          out_valid_d = 1'b0;
          pc_d        = redirect_addr;
        end else begin
          if (handshake_s) begin
            count_d = count_inc_s;
          end else begin
            count_d = count_q;
          end
          if (!out_valid_q || out_ready) begin
            out_instr_d = mem_rd_s;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(1);
            if (mem_rd_s == HALT_WORD) begin
              state_d = ST_HALT;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_HALT: begin
        load_err_d = load_en;
        if (stop) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else if (redirect_valid) begin
          state_d     = ST_FETCH;
          out_valid_d = 1'b0;
          pc_d        = redirect_addr;
        end else if (handshake_s) begin
          // The HALT word itself is delivered and counted before going quiet.
          out_valid_d = 1'b0;
          count_d     = count_inc_s;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= {ADDR_W{1'b0}};
      out_valid_q <= 1'b0;
      out_instr_q <= {DATA_W{1'b0}};
      out_pc_q    <= {ADDR_W{1'b0}};
      load_err_q  <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      load_err_q  <= load_err_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign load_err    = load_err_q;
  assign instr_count = count_q;
  assign busy        = (state_q == ST_FETCH);
  assign halted      = (state_q == ST_HALT);

endmodule
